// File: rtl/rp_prune_seq.sv
// Sequencer for the random-projection pruning pass: walks the hypervector chunk by chunk,
// drives the accumulators, strobes rp_ctrl and assembles the full-width keep-mask.
module rp_prune_seq #(
  parameter int unsigned HV_DIM          = 4096,
  parameter int unsigned DIMS_PER_CC     = 1024,
  parameter int unsigned SEQ_CYCLE_COUNT = 4,
  parameter int unsigned NUM_FEATURES    = 617,
  localparam int unsigned CW = (SEQ_CYCLE_COUNT > 1) ? $clog2(SEQ_CYCLE_COUNT) : 1,
  localparam int unsigned FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
  localparam int unsigned AW = $clog2(HV_DIM + 1)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DIMS_PER_CC-1:0] enable_signal,
  output logic                   busy,
  output logic                   done,
  output logic [CW-1:0]          chunk_sel,
  output logic [FW-1:0]          feat_idx,
  output logic                   acc_clr,
  output logic                   acc_en,
  output logic                   pruning_hv,
  output logic [HV_DIM-1:0]      prune_mask,
  output logic [AW-1:0]          active_count,
  output logic [2:0]             dbg_state
);

  localparam int unsigned PW = $clog2(DIMS_PER_CC + 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(SEQ_CYCLE_COUNT - 1);
  localparam logic [FW-1:0] LAST_FEAT  = FW'(NUM_FEATURES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ACC   = 3'd2,
    S_PRUNE = 3'd3,
    S_CAPT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;
  logic [PW-1:0] pop;

  assign dbg_state = state;

  // Handshake: start is accepted only on a cycle where busy is low; busy then stays high
  // until the cycle after the done pulse (or after an abort edge), done is a single-cycle strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLR;
      S_CLR:   state_nxt = S_ACC;
      S_ACC:   if (feat_idx == LAST_FEAT) state_nxt = S_PRUNE;
      S_PRUNE: state_nxt = S_CAPT;
      S_CAPT:  state_nxt = (chunk_sel == LAST_CHUNK) ? S_DONE : S_CLR;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_nxt = S_IDLE;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(DIMS_PER_CC); i++) pop = pop + PW'(enable_signal[i]);
  end

  // Strobes are registered from the next state so they line up exactly with the state they flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      acc_clr      <= 1'b0;
      acc_en       <= 1'b0;
      pruning_hv   <= 1'b0;
      chunk_sel    <= '0;
      feat_idx     <= '0;
      prune_mask   <= '0;
      active_count <= '0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_DONE);
      acc_clr    <= (state_nxt == S_CLR);
      acc_en     <= (state_nxt == S_ACC);
      pruning_hv <= (state_nxt == S_PRUNE);
      if (abort && state != S_IDLE) begin
        chunk_sel    <= '0;
        feat_idx     <= '0;
        prune_mask   <= '0;
        active_count <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              chunk_sel    <= '0;
              prune_mask   <= '0;
              active_count <= '0;
            end
          end
          S_CLR: feat_idx <= '0;
          S_ACC: feat_idx <= (feat_idx == LAST_FEAT) ? '0 : feat_idx + FW'(1);
          S_CAPT: begin
            for (int c = 0; c < int'(SEQ_CYCLE_COUNT); c++) begin
              if (chunk_sel == CW'(c))
                prune_mask[c*DIMS_PER_CC +: DIMS_PER_CC] <= enable_signal;
            end
            active_count <= active_count + AW'(pop);
            if (chunk_sel != LAST_CHUNK) chunk_sel <= chunk_sel + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rp_prune_seq.sv
// Bench for rp_prune_seq with a short feature loop; rp_ctrl is replaced by a per-chunk pattern stub.
module tb_rp_prune_seq;

  localparam int HV = 4096;
  localparam int D  = 1024;
  localparam int F  = 3;

  logic            clk, nrst, start, abort;
  logic [D-1:0]    enable_signal;
  logic            busy, done, acc_clr, acc_en, pruning_hv;
  logic [1:0]      chunk_sel;
  logic [1:0]      feat_idx;
  logic [HV-1:0]   prune_mask;
  logic [12:0]     active_count;
  logic [2:0]      dbg_state;

  rp_prune_seq #(.NUM_FEATURES(F)) dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort), .enable_signal(enable_signal),
    .busy(busy), .done(done), .chunk_sel(chunk_sel), .feat_idx(feat_idx),
    .acc_clr(acc_clr), .acc_en(acc_en), .pruning_hv(pruning_hv),
    .prune_mask(prune_mask), .active_count(active_count), .dbg_state(dbg_state)
  );

  // clock / cycle base
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // rp_ctrl stub: registers the chunk's pattern on the pruning strobe
  logic [D-1:0] pat [4];
  always @(posedge clk) if (pruning_hv) enable_signal <= pat[chunk_sel];

  int n_checks = 0;
  int n_fail   = 0;
  int e0_mark  = 0;
  int acc_total = 0, prn_total = 0, done_total = 0;

  logic [12:0]   exp_q[$];
  logic [HV-1:0] exp_mask_q[$];
  logic [12:0]   ec;
  logic [HV-1:0] em;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cur_cyc();
    return cyc_cnt - e0_mark + 1;
  endfunction

  task automatic push_expected();
    logic [HV-1:0] m;
    m = {pat[3], pat[2], pat[1], pat[0]};
    exp_mask_q.push_back(m);
    exp_q.push_back(13'($countones(m)));
  endtask

  task automatic mark_e0();
    e0_mark   = cyc_cnt;
    acc_total = 0;
    prn_total = 0;
  endtask

  task automatic drive_start(input bit hold);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 mark_e0();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cur_cyc() < n);
  endtask

  task automatic wait_done(input int budget, output int dc);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    dc = cur_cyc();
    if (!done) check("done_timeout", 64'(k), 64'(budget + 1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_acc_clr"}, acc_clr, 0);
    check({tag, "_acc_en"}, acc_en, 0);
    check({tag, "_pruning_hv"}, pruning_hv, 0);
    check({tag, "_chunk_sel"}, chunk_sel, 0);
    check({tag, "_feat_idx"}, feat_idx, 0);
    check({tag, "_mask_bits"}, $countones(prune_mask), 0);
    check({tag, "_active_count"}, active_count, 0);
  endtask

  // scoreboard / activity monitor
  always @(negedge clk) begin
    if (acc_en) acc_total++;
    if (pruning_hv) prn_total++;
    if (done) begin
      done_total++;
      check("done_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        ec = exp_q.pop_front();
        em = exp_mask_q.pop_front();
        check("sb_active_count", active_count, ec);
        check("sb_mask_diff_bits", $countones(prune_mask ^ em), 0);
      end
    end
  end

  initial begin
    int dc, d0;
    for (int c = 0; c < 4; c++) pat[c] = '1;
    abort = 1'b0;
    start = 1'b1;
    nrst  = 1'b0;

    // reset with start stuck high, then full keep
    #12;
    check_all_zero("reset");
    push_expected();
    @(negedge clk) nrst = 1'b1;
    @(posedge clk);
    #1 mark_e0();
    @(negedge clk);
    check("busy_after_release", busy, 1);
    start = 1'b0;
    wait_done(60, dc);
    check("full_done_cycle", dc, 25);
    check("full_active_count", active_count, 4096);
    check("full_mask_ones", $countones(prune_mask), 4096);
    check("full_acc_en_cycles", acc_total, 12);
    check("full_prune_pulses", prn_total, 4);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("full_mask_hold", $countones(prune_mask), 4096);

    // per-chunk patterns
    pat[0] = '0;
    pat[1] = {512{2'b01}};
    pat[2] = D'(1) << 7;
    pat[3] = '1;
    push_expected();
    drive_start(1'b0);
    wait_done(60, dc);
    check("pat_done_cycle", dc, 25);
    check("pat_active_count", active_count, 1537);
    check("pat_bit_2055", prune_mask[2055], 1);
    check("pat_chunk3_ones", $countones(prune_mask[4095:3072]), 1024);
    check("pat_chunk0_zero", $countones(prune_mask[1023:0]), 0);

    // start pulse while busy is ignored
    push_expected();
    drive_start(1'b0);
    wait_cyc(10);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(60, dc);
    check("ignored_start_done_cycle", dc, 25);
    @(negedge clk);
    check("ignored_start_idle_26", busy, 0);
    @(negedge clk);
    check("ignored_start_idle_27", busy, 0);

    // start held high: back-to-back passes
    push_expected();
    push_expected();
    drive_start(1'b1);
    wait_done(60, dc);
    check("held_first_done_cycle", dc, 25);
    @(negedge clk);
    check("held_idle_26", busy, 0);
    @(negedge clk);
    check("held_busy_27", busy, 1);
    check("held_count_27", active_count, 0);
    start = 1'b0;
    wait_done(60, dc);
    check("held_second_done_cycle", dc, 51);

    // abort during chunk 2 accumulation
    pat[0] = '1;
    drive_start(1'b0);
    wait_cyc(15);
    check("abort_pre_chunk", chunk_sel, 2);
    check("abort_pre_acc_en", acc_en, 1);
    d0 = done_total;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_mask_bits", $countones(prune_mask), 0);
    check("abort_active_count", active_count, 0);
    check("abort_chunk_sel", chunk_sel, 0);
    check("abort_feat_idx", feat_idx, 0);
    repeat (30) @(negedge clk);
    check("abort_no_done", done_total, d0);

    // reset during chunk 1 prune
    for (int c = 0; c < 4; c++) pat[c] = '1;
    drive_start(1'b0);
    wait_cyc(11);
    check("midrst_pre_prune", pruning_hv, 1);
    check("midrst_pre_mask", $countones(prune_mask), 1024);
    #2 nrst = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk) nrst = 1'b1;
    push_expected();
    drive_start(1'b0);
    wait_done(60, dc);
    check("midrst_done_cycle", dc, 25);
    check("midrst_active_count", active_count, 4096);
    repeat (3) @(negedge clk);

    check("sb_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
